uart_transmit: RTL and testbench

//  Serial UART transmitter for the SoC's processor-to-serial path. Accepts one byte per

---
 rtl/uart_transmit.sv | 144 ++++++++++++++
 tb/tb_uart_transmit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/uart_transmit.sv
// rtl/uart_transmit.sv - UART transmitter: frames one byte per Load strobe and shifts it out on transfer
//
// Purpose: serial transmitter for the processor-to-serial path. A byte is framed
// as start bit, 7 or 8 data bits LSB first, optional parity, then stop bits,
// padded with 1s to FRAME_BITS bit times. Each bit time lasts k clocks.
//
// Ports:
//   clk       in   1   system clock, rising edge
//   reset     in   1   asynchronous active-low reset
//   Load      in   1   write strobe, byte accepted when Load=1 and txrdy=1
//   out_port  in   8   byte to transmit
//   eight     in   1   1 = 8 data bits, 0 = 7 data bits (out_port[6:0])
//   pen       in   1   parity enable
//   ohel      in   1   parity sense, 1 = odd, 0 = even
//   k         in   KW  clocks per bit time (0 behaves as 1)
//   txrdy     out  1   1 = idle and ready for Load
//   transfer  out  1   serial line, idles high
//
// Configuration macro: UART_TX_LOAD_EDGE_EN
//   defined   - accept only on a 0->1 transition of Load while idle
//   undefined - level-sensitive acceptance (Load held high sends back-to-back frames)

module uart_transmit #(
    parameter int FRAME_BITS = 11,
    parameter int KW         = 20
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          Load,
    input  logic [7:0]    out_port,
    input  logic          eight,
    input  logic          pen,
    input  logic          ohel,
    input  logic [KW-1:0] k,
    output logic          txrdy,
    output logic          transfer
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

    state_t                state;
    logic [FRAME_BITS-1:0] shift_reg;
    logic [KW-1:0]         baud_cnt;
    logic [KW-1:0]         k_lat;
    logic [3:0]            bit_cnt;
    logic                  start_pending;
    logic                  accept;
    logic                  parity;
    logic [FRAME_BITS-1:0] frame;
    logic [KW-1:0]         k_eff;

`ifdef UART_TX_LOAD_EDGE_EN
    logic load_prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            load_prev <= 1'b0;
        end else begin
            load_prev <= Load;
        end
    end

    // A rising edge seen while BUSY is simply not acted upon, so it is dropped.
    assign accept = Load & ~load_prev;
`else
    assign accept = Load;
`endif

    // Frame image, bit 0 goes out first. Unused slots stay 1 (stop level).
    always_comb begin
        parity = (eight ? ^out_port : ^out_port[6:0]) ^ ohel;
        frame    = '1;
        frame[0] = 1'b0;
        if (eight) begin
            frame[8:1] = out_port;
            if (pen) begin
                frame[9] = parity;
            end
        end else begin
            frame[7:1] = out_port[6:0];
            if (pen) begin
                frame[8] = parity;
            end
        end
        k_eff = (k == '0) ? KW'(1) : k;
    end

    // The baud counter is preloaded to its terminal value on accept so that the
    // start bit is driven on the very next edge; start_pending marks that first
    // shift so bit_cnt always names the bit currently on the line.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            shift_reg     <= '1;
            baud_cnt      <= '0;
            bit_cnt       <= '0;
            k_lat         <= KW'(1);
            start_pending <= 1'b0;
            txrdy         <= 1'b1;
            transfer      <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    transfer <= 1'b1;
                    txrdy    <= 1'b1;
                    if (accept) begin
                        shift_reg     <= frame;
                        k_lat         <= k_eff;
                        baud_cnt      <= k_eff - KW'(1);
                        bit_cnt       <= '0;
                        start_pending <= 1'b1;
                        txrdy         <= 1'b0;
                        state         <= BUSY;
                    end
                end
                BUSY: begin
                    if (baud_cnt == k_lat - KW'(1)) begin
                        baud_cnt <= '0;
                        if (start_pending) begin
                            start_pending <= 1'b0;
                            transfer      <= shift_reg[0];
                            shift_reg     <= {1'b1, shift_reg[FRAME_BITS-1:1]};
                        end else if (bit_cnt == LAST_BIT) begin
                            transfer  <= 1'b1;
                            txrdy     <= 1'b1;
                            shift_reg <= '1;
                            state     <= IDLE;
                        end else begin
                            bit_cnt   <= bit_cnt + 4'd1;
                            transfer  <= shift_reg[0];
                            shift_reg <= {1'b1, shift_reg[FRAME_BITS-1:1]};
                        end
                    end else begin
                        baud_cnt <= baud_cnt + KW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_transmit.sv
// tb/tb_uart_transmit.sv - self-checking bench for uart_transmit

module tb_uart_transmit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        Load = 1'b0;
    logic [7:0]  out_port = 8'h00;
    logic        eight = 1'b0;
    logic        pen = 1'b0;
    logic        ohel = 1'b0;
    logic [19:0] k = 20'd0;
    logic        txrdy;
    logic        transfer;

    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct {
        logic [7:0]  d;
        logic        e;
        logic        p;
        logic        o;
        logic [19:0] kk;
        logic [10:0] exp;
    } vec_t;

    vec_t tbl[8];

    always #5 clk = ~clk;

    uart_transmit #(.FRAME_BITS(11), .KW(20)) dut (
        .clk(clk),
        .reset(reset),
        .Load(Load),
        .out_port(out_port),
        .eight(eight),
        .pen(pen),
        .ohel(ohel),
        .k(k),
        .txrdy(txrdy),
        .transfer(transfer)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference frame built from the framing rules: start 0, data LSB first,
    // parity chosen so the total count of ones is even (ohel=0) or odd (ohel=1),
    // then 1s up to 11 bit times.
    function automatic logic [10:0] model_frame(input logic [7:0] d, input logic e, input logic p, input logic o);
        bit q[$];
        int n;
        int ones;
        logic [10:0] f;
        n = e ? 8 : 7;
        ones = 0;
        q.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            q.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (p) q.push_back(o ? ((ones % 2) == 0) : ((ones % 2) == 1));
        while (q.size() < 11) q.push_back(1'b1);
        for (int i = 0; i < 11; i++) f[i] = q[i];
        return f;
    endfunction

    task automatic run_frame(input string tag, input logic [7:0] d, input logic e, input logic p,
                             input logic o, input logic [19:0] kk, input logic [10:0] exp, input bit disturb);
        int keff;
        int bad;
        int s;
        int dis_at;
        keff = (kk == 20'd0) ? 1 : int'(kk);
        dis_at = disturb ? int'($urandom_range(0, 11 * keff - 3)) : -10;
        @(negedge clk);
        out_port = d; eight = e; pen = p; ohel = o; k = kk; Load = 1'b1;
        @(posedge clk);
        @(negedge clk);
        Load = 1'b0;
        check({tag, "/pre"}, 32'({transfer, txrdy}), 32'b10);
        s = 0;
        for (int i = 0; i < 11; i++) begin
            bad = 0;
            for (int c = 0; c < keff; c++) begin
                @(negedge clk);
                if (transfer !== exp[i] || txrdy !== 1'b0) bad++;
                if (s == dis_at) begin
                    Load = 1'b1;
                    out_port = 8'($urandom);
                    eight = 1'($urandom);
                    pen = 1'($urandom);
                    ohel = 1'($urandom);
                    k = 20'($urandom_range(0, 9));
                end else if (s == dis_at + 1) begin
                    Load = 1'b0;
                end
                s++;
            end
            check($sformatf("%s/bit%0d", tag, i), 32'(bad), 32'd0);
        end
        @(negedge clk);
        check({tag, "/end"}, 32'({transfer, txrdy}), 32'b11);
        repeat (3) @(negedge clk);
        check({tag, "/quiet"}, 32'({transfer, txrdy}), 32'b11);
    endtask

    int bad;
    int falls;
    logic prev_rdy;
    logic [7:0] rd;
    logic re, rp, ro;
    logic [19:0] rk;
    int exp_frames;

    initial begin
        tbl[0] = '{8'hB9, 1'b1, 1'b1, 1'b1, 20'd109, 11'b10101110010};
        tbl[1] = '{8'hB9, 1'b1, 1'b1, 1'b0, 20'd109, 11'b11101110010};
        tbl[2] = '{8'hB9, 1'b1, 1'b0, 1'b1, 20'd7,   11'b11101110010};
        tbl[3] = '{8'h41, 1'b0, 1'b1, 1'b0, 20'd4,   11'b11010000010};
        tbl[4] = '{8'hC1, 1'b0, 1'b1, 1'b0, 20'd3,   11'b11010000010};
        tbl[5] = '{8'h41, 1'b0, 1'b0, 1'b1, 20'd2,   11'b11110000010};
        tbl[6] = '{8'h00, 1'b1, 1'b1, 1'b1, 20'd0,   11'b11000000000};
        tbl[7] = '{8'hFF, 1'b1, 1'b1, 1'b0, 20'd1,   11'b10111111110};

        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("reset", 32'({transfer, txrdy}), 32'b11);
        reset = 1'b1;
        bad = 0;
        repeat (300) begin
            @(negedge clk);
            if ({transfer, txrdy} !== 2'b11) bad++;
        end
        check("idle", 32'(bad), 32'd0);

        for (int i = 0; i < 8; i++)
            run_frame($sformatf("vec%0d", i), tbl[i].d, tbl[i].e, tbl[i].p, tbl[i].o, tbl[i].kk, tbl[i].exp, 1'b0);

        run_frame("pulse", 8'hB9, 1'b1, 1'b1, 1'b1, 20'd5, 11'b10101110010, 1'b1);

        for (int i = 0; i < 12; i++) begin
            rd = 8'($urandom);
            re = 1'($urandom);
            rp = 1'($urandom);
            ro = 1'($urandom);
            rk = 20'($urandom_range(0, 6));
            run_frame($sformatf("rnd%0d", i), rd, re, rp, ro, rk, model_frame(rd, re, rp, ro), 1'($urandom));
        end

        // Load held high: frame period is 11*k+2 clocks, hold for 2.5 periods.
`ifdef UART_TX_LOAD_EDGE_EN
        exp_frames = 1;
`else
        exp_frames = 3;
`endif
        @(negedge clk);
        out_port = 8'h3C; eight = 1'b1; pen = 1'b0; ohel = 1'b0; k = 20'd3; Load = 1'b1;
        falls = 0;
        prev_rdy = 1'b1;
        repeat (87) begin
            @(negedge clk);
            if (prev_rdy && !txrdy) falls++;
            prev_rdy = txrdy;
        end
        Load = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (prev_rdy && !txrdy) falls++;
            prev_rdy = txrdy;
        end
        check("hold_frames", 32'(falls), 32'(exp_frames));
        check("hold_end", 32'({transfer, txrdy}), 32'b11);

        // Asynchronous abort during bit 5 (d4 of 8'h4A is 0).
        @(negedge clk);
        out_port = 8'h4A; eight = 1'b1; pen = 1'b1; ohel = 1'b0; k = 20'd5; Load = 1'b1;
        @(posedge clk);
        @(negedge clk);
        Load = 1'b0;
        repeat (28) @(negedge clk);
        check("pre_abort", 32'({transfer, txrdy}), 32'b00);
        #2 reset = 1'b0;
        #1 check("abort", 32'({transfer, txrdy}), 32'b11);
        @(negedge clk);
        check("abort_hold", 32'({transfer, txrdy}), 32'b11);
        reset = 1'b1;
        run_frame("after_rst", 8'h4A, 1'b1, 1'b1, 1'b0, 20'd5, model_frame(8'h4A, 1'b1, 1'b1, 1'b0), 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
